// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle control FSM for the CPU datapath with bounded memory handshake
module control_unit #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ir1,
    input  logic [2:0] ir2,
    input  logic       dcond,
    input  logic       mem_ready,
    output logic       tmar,
    output logic       ldmar,
    output logic       tmdr,
    output logic       ldmdr,
    output logic       tsp,
    output logic       ldsp,
    output logic       tpc,
    output logic       ldpc,
    output logic       ldt,
    output logic       tir,
    output logic       ldir,
    output logic       rd,
    output logic       wr,
    output logic       memrd,
    output logic       memwr,
    output logic       m1,
    output logic       m2,
    output logic [2:0] fnotsel_cont,
    output logic       halted,
    output logic       fault
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

    localparam logic [4:0] S_F0    = 5'd0;
    localparam logic [4:0] S_F1    = 5'd1;
    localparam logic [4:0] S_F2    = 5'd2;
    localparam logic [4:0] S_F3    = 5'd3;
    localparam logic [4:0] S_DEC   = 5'd4;
    localparam logic [4:0] S_J0    = 5'd5;
    localparam logic [4:0] S_A0    = 5'd6;
    localparam logic [4:0] S_A1    = 5'd7;
    localparam logic [4:0] S_L0    = 5'd8;
    localparam logic [4:0] S_L1    = 5'd9;
    localparam logic [4:0] S_L2    = 5'd10;
    localparam logic [4:0] S_S0    = 5'd11;
    localparam logic [4:0] S_S1    = 5'd12;
    localparam logic [4:0] S_MOVR  = 5'd13;
    localparam logic [4:0] S_MOVM  = 5'd14;
    localparam logic [4:0] S_P0    = 5'd15;
    localparam logic [4:0] S_P1    = 5'd16;
    localparam logic [4:0] S_P2    = 5'd17;
    localparam logic [4:0] S_HALT  = 5'd18;
    localparam logic [4:0] S_FAULT = 5'd19;

    localparam logic [2:0] FN_INC   = 3'b100;
    localparam logic [2:0] FN_DEC   = 3'b101;
    localparam logic [2:0] FN_PASSX = 3'b110;

    logic [4:0]    state;
    logic [4:0]    state_nx;
    logic [4:0]    wait_exit;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nx;
    logic          in_wait;

    // ir2 steers the datapath ALU mux directly when m1=1; nothing here needs its value.
    logic unused_ir2;
    assign unused_ir2 = ^ir2;

    assign in_wait = (state == S_F1) || (state == S_L1) || (state == S_S1) || (state == S_P2);

    always_comb begin
        state_nx    = state;
        wait_exit   = S_F0;
        wait_cnt_nx = '0;
        case (state)
            S_F0:   state_nx = S_F1;
            S_F1:   wait_exit = S_F2;
            S_F2:   state_nx = S_F3;
            S_F3:   state_nx = S_DEC;
            S_DEC: begin
                case (ir1)
                    4'h9:    state_nx = S_A0;
                    4'hA:    state_nx = S_L0;
                    4'hB:    state_nx = S_S0;
                    4'hC:    state_nx = S_MOVR;
                    4'hD:    state_nx = S_MOVM;
                    4'hE:    state_nx = S_P0;
                    4'hF:    state_nx = S_HALT;
                    default: state_nx = dcond ? S_J0 : S_F0;
                endcase
            end
            S_J0:    state_nx = S_F0;
            S_A0:    state_nx = S_A1;
            S_A1:    state_nx = S_F0;
            S_L0:    state_nx = S_L1;
            S_L1:    wait_exit = S_L2;
            S_L2:    state_nx = S_F0;
            S_S0:    state_nx = S_S1;
            S_S1:    wait_exit = S_F0;
            S_MOVR:  state_nx = S_F0;
            S_MOVM:  state_nx = S_F0;
            S_P0:    state_nx = S_P1;
            S_P1:    state_nx = S_P2;
            S_P2:    wait_exit = S_F0;
            S_HALT:  state_nx = S_HALT;
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_F0;
        endcase
        // Shared handshake: ready wins over the limit on the same cycle.
        if (in_wait) begin
            if (mem_ready) begin
                state_nx = wait_exit;
            end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                state_nx = S_FAULT;
            end else begin
                wait_cnt_nx = wait_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_F0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        tmar = 1'b0; ldmar = 1'b0; tmdr = 1'b0; ldmdr = 1'b0;
        tsp  = 1'b0; ldsp  = 1'b0; tpc  = 1'b0; ldpc  = 1'b0;
        ldt  = 1'b0; tir   = 1'b0; ldir = 1'b0; rd    = 1'b0;
        wr   = 1'b0; memrd = 1'b0; memwr = 1'b0; m1   = 1'b0;
        m2   = 1'b0; halted = 1'b0; fault = 1'b0;
        fnotsel_cont = FN_PASSX;
        case (state)
            S_F0:    begin tpc = 1'b1; ldmar = 1'b1; end
            S_F1:    begin memrd = 1'b1; tmar = 1'b1; end
            S_F2:    begin memrd = 1'b1; tmar = 1'b1; ldir = 1'b1; end
            S_F3:    begin tpc = 1'b1; ldpc = 1'b1; fnotsel_cont = FN_INC; end
            S_J0:    begin tir = 1'b1; ldpc = 1'b1; end
            S_A0:    begin rd = 1'b1; ldt = 1'b1; end
            S_A1:    begin tmdr = 1'b1; m1 = 1'b1; wr = 1'b1; end
            S_L0:    begin rd = 1'b1; ldmar = 1'b1; end
            S_L1:    begin memrd = 1'b1; tmar = 1'b1; end
            S_L2:    begin memrd = 1'b1; tmar = 1'b1; ldmdr = 1'b1; end
            S_S0:    begin rd = 1'b1; ldmar = 1'b1; end
            S_S1:    begin memwr = 1'b1; tmar = 1'b1; end
            S_MOVR:  begin rd = 1'b1; m2 = 1'b1; ldmdr = 1'b1; end
            S_MOVM:  begin tmdr = 1'b1; wr = 1'b1; end
            S_P0:    begin tsp = 1'b1; ldsp = 1'b1; fnotsel_cont = FN_DEC; end
            S_P1:    begin tsp = 1'b1; ldmar = 1'b1; end
            S_P2:    begin memwr = 1'b1; tmar = 1'b1; end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
        // Outputs must drop immediately while reset is held, even though F0 drives tpc/ldmar.
        if (!rst_n) begin
            tmar = 1'b0; ldmar = 1'b0; tmdr = 1'b0; ldmdr = 1'b0;
            tsp  = 1'b0; ldsp  = 1'b0; tpc  = 1'b0; ldpc  = 1'b0;
            ldt  = 1'b0; tir   = 1'b0; ldir = 1'b0; rd    = 1'b0;
            wr   = 1'b0; memrd = 1'b0; memwr = 1'b0; m1   = 1'b0;
            m2   = 1'b0; halted = 1'b0; fault = 1'b0;
            fnotsel_cont = FN_PASSX;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized instruction-level check of control_unit against a sequence model
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ir1 = 4'h0;
    logic [2:0] ir2 = 3'h0;
    logic       dcond = 1'b0;
    logic       mem_ready = 1'b0;
    logic tmar, ldmar, tmdr, ldmdr, tsp, ldsp, tpc, ldpc, ldt, tir, ldir, rd, wr;
    logic memrd, memwr, m1, m2, halted, fault;
    logic [2:0] fnotsel_cont;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] cur_ir1;
    logic [2:0] cur_ir2;
    logic       cur_dcond;

    always #5 clk = ~clk;

    control_unit #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir1(ir1), .ir2(ir2), .dcond(dcond), .mem_ready(mem_ready),
        .tmar(tmar), .ldmar(ldmar), .tmdr(tmdr), .ldmdr(ldmdr), .tsp(tsp), .ldsp(ldsp),
        .tpc(tpc), .ldpc(ldpc), .ldt(ldt), .tir(tir), .ldir(ldir), .rd(rd), .wr(wr),
        .memrd(memrd), .memwr(memwr), .m1(m1), .m2(m2), .fnotsel_cont(fnotsel_cont),
        .halted(halted), .fault(fault)
    );

    localparam logic [21:0] TMAR   = 22'd1 << 21;
    localparam logic [21:0] LDMAR  = 22'd1 << 20;
    localparam logic [21:0] TMDR   = 22'd1 << 19;
    localparam logic [21:0] LDMDR  = 22'd1 << 18;
    localparam logic [21:0] TSP    = 22'd1 << 17;
    localparam logic [21:0] LDSP   = 22'd1 << 16;
    localparam logic [21:0] TPC    = 22'd1 << 15;
    localparam logic [21:0] LDPC   = 22'd1 << 14;
    localparam logic [21:0] LDT    = 22'd1 << 13;
    localparam logic [21:0] TIR    = 22'd1 << 12;
    localparam logic [21:0] LDIR   = 22'd1 << 11;
    localparam logic [21:0] RD     = 22'd1 << 10;
    localparam logic [21:0] WR     = 22'd1 << 9;
    localparam logic [21:0] MEMRD  = 22'd1 << 8;
    localparam logic [21:0] MEMWR  = 22'd1 << 7;
    localparam logic [21:0] M1     = 22'd1 << 6;
    localparam logic [21:0] M2     = 22'd1 << 5;
    localparam logic [21:0] HALTED = 22'd1 << 1;
    localparam logic [21:0] FAULT  = 22'd1;
    localparam logic [21:0] PX     = {17'd0, 3'b110, 2'd0};
    localparam logic [21:0] INC    = {17'd0, 3'b100, 2'd0};
    localparam logic [21:0] DECR   = {17'd0, 3'b101, 2'd0};

    logic [21:0] obs;
    assign obs = {tmar, ldmar, tmdr, ldmdr, tsp, ldsp, tpc, ldpc, ldt, tir, ldir, rd, wr,
                  memrd, memwr, m1, m2, fnotsel_cont, halted, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, check Moore outputs, advance to next negedge.
    // rdy: 0/1 drive that value, 2 random (must be ignored). live: drive the real opcode fields.
    task automatic step(input string tag, input logic [21:0] exp, input int rdy, input bit live);
        if (live) begin
            ir1 = cur_ir1; ir2 = cur_ir2; dcond = cur_dcond;
        end else begin
            ir1 = 4'($urandom); ir2 = 3'($urandom); dcond = 1'($urandom);
        end
        mem_ready = (rdy == 2) ? 1'($urandom) : (rdy == 1);
        #1;
        check(tag, {10'd0, obs}, {10'd0, exp});
        check("xbus_single", {31'd0, ($countones({tsp, tpc, tmdr, tir, rd}) <= 1)}, 32'd1);
        check("tmar_eq_req", {31'd0, tmar}, {31'd0, memrd | memwr});
        @(negedge clk);
    endtask

    task automatic access(input string tag, input logic [21:0] exp, input int delay);
        for (int i = 0; i < delay; i++) step(tag, exp, 0, 1'b0);
        step(tag, exp, 1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {10'd0, obs}, {10'd0, PX});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch(input int df);
        step("F0", TPC | LDMAR | PX, 2, 1'b0);
        access("F1", MEMRD | TMAR | PX, df);
        step("F2", MEMRD | TMAR | LDIR | PX, 2, 1'b0);
        step("F3", TPC | LDPC | INC, 2, 1'b0);
        step("DEC", PX, 2, 1'b1);
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input logic dc,
                             input int df, input int de);
        cur_ir1 = op; cur_ir2 = fn; cur_dcond = dc;
        fetch(df);
        case (op)
            4'h9: begin
                step("A0", RD | LDT | PX, 2, 1'b0);
                step("A1", TMDR | M1 | WR | PX, 2, 1'b1);
            end
            4'hA: begin
                step("L0", RD | LDMAR | PX, 2, 1'b0);
                access("L1", MEMRD | TMAR | PX, de);
                step("L2", MEMRD | TMAR | LDMDR | PX, 2, 1'b0);
            end
            4'hB: begin
                step("S0", RD | LDMAR | PX, 2, 1'b0);
                access("S1", MEMWR | TMAR | PX, de);
            end
            4'hC: step("MOVR", RD | M2 | LDMDR | PX, 2, 1'b0);
            4'hD: step("MOVM", TMDR | WR | PX, 2, 1'b0);
            4'hE: begin
                step("P0", TSP | LDSP | DECR, 2, 1'b0);
                step("P1", TSP | LDMAR | PX, 2, 1'b0);
                access("P2", MEMWR | TMAR | PX, de);
            end
            4'hF: begin
                for (int i = 0; i < 3; i++) step("HALT", HALTED | PX, 2, 1'b0);
                do_reset();
            end
            default: if (dc) step("J0", TIR | LDPC | PX, 2, 1'b0);
        endcase
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("reset_held", {10'd0, obs}, {10'd0, PX});
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(4'hD, 3'd0, 1'b0, 0, 0);
        run_instr(4'h3, 3'd0, 1'b1, 0, 0);
        run_instr(4'h3, 3'd0, 1'b0, 0, 0);
        run_instr(4'h9, 3'b010, 1'b0, 0, 0);
        run_instr(4'hE, 3'd0, 1'b0, 0, 3);
        run_instr(4'hA, 3'd0, 1'b0, 3, 3);

        for (int n = 0; n < 120; n++)
            run_instr(4'($urandom), 3'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset asserted in the middle of a load wait.
        cur_ir1 = 4'hA; cur_ir2 = 3'd0; cur_dcond = 1'b0;
        fetch(0);
        step("L0", RD | LDMAR | PX, 2, 1'b0);
        step("L1", MEMRD | TMAR | PX, 0, 1'b0);
        step("L1", MEMRD | TMAR | PX, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_L1", {10'd0, obs}, {10'd0, PX});
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'hB, 3'd0, 1'b0, 1, 2);

        // Memory never answers in fetch: fault after WAIT_LIMIT wait cycles.
        step("F0", TPC | LDMAR | PX, 2, 1'b0);
        for (int i = 0; i < 4; i++) step("F1_stuck", MEMRD | TMAR | PX, 0, 1'b0);
        for (int i = 0; i < 4; i++) step("FAULT", FAULT | PX, 2, 1'b0);
        do_reset();
        run_instr(4'hC, 3'd0, 1'b0, 0, 0);
        run_instr(4'hF, 3'd0, 1'b0, 2, 0);
        run_instr(4'h0, 3'd0, 1'b1, 0, 0);
        step("F0_final", TPC | LDMAR | PX, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
